pixel_rom_arbiter: RTL and testbench
====================================

Name: pixel_rom_arbiter

Overview:
Shares the single read port of the image block ROM between two requesters. The display address generator has strict priority. The game-logic requester (collision and light-map lookups) receives idle slots. The block sits between game_display/game_play and the block ROM instance, and its return path is tagged so the ROM stays fully pipelined.

Parameters:
AW, 17, ROM address width
DW, 12, ROM data width (RGB444)
RD_LAT, 2, ROM read latency in clk cycles from mem_addr valid to mem_dout valid (legal range 1..4)
STARVE_LIM, 64, consecutive denied logic cycles before the starve flag asserts

Ports:
clk  in  1  system clock, single domain
rst  in  1  asynchronous, active-low reset
disp_req  in  1  display fetch request, sampled every cycle, never stalled
disp_addr  in  AW  display fetch address
disp_data  out  DW  display pixel, registered, held between valids
disp_valid  out  1  one-cycle pulse, disp_data updated
lg_req  in  1  logic read request, held until lg_ack
lg_addr  in  AW  logic read address, captured at grant
lg_ack  out  1  one-cycle pulse, request accepted
lg_data  out  DW  logic read result, held until the next lg_done
lg_done  out  1  one-cycle pulse, lg_data valid
mem_addr  out  AW  ROM address, registered
mem_en  out  1  ROM read enable, registered
mem_dout  in  DW  ROM read data
starve  out  1  logic requester starved, level signal

Behaviour:
- Reset (rst=0, asynchronous):
  - mem_addr=0, mem_en=0.
  - disp_data=0, disp_valid=0, lg_data=0, lg_ack=0, lg_done=0, starve=0.
  - FSM goes to IDLE, tag pipe clears to TAG_NONE, starve counter=0.
- Grant per cycle, decided at the clock edge:
  - If disp_req=1, the display wins: mem_addr<=disp_addr, mem_en<=1, tag TAG_DISP.
  - Otherwise, if FSM=IDLE and lg_req=1, logic wins: mem_addr<=lg_addr, mem_en<=1, tag TAG_LG, lg_ack<=1 for one cycle, FSM->WAIT.
  - Otherwise mem_en<=0, mem_addr holds its value, tag TAG_NONE.
- Tag pipe: a shift register RD_LAT+1 deep, aligned so the output tag matches mem_dout.
  - Output TAG_DISP: disp_data<=mem_dout, disp_valid<=1.
  - Output TAG_LG: lg_data<=mem_dout, lg_done<=1, FSM WAIT->IDLE.
- Latency: request sampled at edge N produces its valid/done pulse in the cycle after edge N+RD_LAT+1. With RD_LAT=2 that is 4 cycles.
- Throughput: one grant per cycle. Display requests continue to be granted while a logic read is in flight.
- FSM states: IDLE (accepting), WAIT (one logic read outstanding; lg_req ignored).
  - The requester drops lg_req after lg_ack.
  - If lg_req is still high when the FSM returns to IDLE, it is a new request.
- Only one outstanding logic read is allowed. Display reads are unlimited.
- lg_addr changes after the grant are ignored. disp_addr is used only in the granted cycle.
- Starve counter:
  - Increments when lg_req=1, FSM=IDLE and the display is granted.
  - Clears on a logic grant or when lg_req=0.
  - Saturates at STARVE_LIM.
  - starve=1 while count>=STARVE_LIM, registered.
- Simultaneous disp_req and lg_req: the display wins. The logic request stays pending with no lg_ack, and the counter increments.
- Reset mid-read: in-flight tags are discarded. No disp_valid or lg_done pulse follows reset release for pre-reset requests.
- disp_valid and lg_done are never high in the same cycle, because each cycle carries exactly one tag.

Decomposition:
- Shared package pixel_rom_pkg holds:
  - AW/DW defaults.
  - Tag constants TAG_NONE=2'b00, TAG_DISP=2'b01, TAG_LG=2'b10.
  - FSM encoding ST_IDLE=1'b0, ST_WAIT=1'b1.
- Sub-module rd_tag_pipe: parameterised by depth RD_LAT+1, with 2-bit tag in and tag out, clk, and async active-low rst.

Test Plan:
1. Display-only read, RD_LAT=2: disp_req=1, disp_addr=0x00123 at edge 0, ROM returns 0xABC. Required: mem_addr=0x00123 and mem_en=1 after edge 0; disp_valid=1 with disp_data=0xABC after edge 3; no lg_done.
2. Logic-only read: lg_req=1, lg_addr=0x1F000, disp_req=0. Required: lg_ack pulses after edge 0; lg_done pulses with the ROM word after edge 3. lg_req held high through that edge re-triggers only after lg_done.
3. Contention: disp_req and lg_req both 1 for 3 cycles, then disp_req=0. Required: three display grants, lg_ack after the 4th edge, starve counter reaches 3 then clears.
4. Interleave: alternating disp_req 1/0 for 8 cycles with lg_req=1 throughout. Required: logic is granted in the first idle slot only; disp_valid pulses 4 cycles after each display grant; tags stay correctly ordered.
5. Starvation: disp_req=1 for 70 cycles with lg_req=1. Required: starve=1 from the cycle after count hits 64; starve=0 one cycle after the logic grant.
6. Reset mid-flight: display and logic reads issued, rst=0 asserted 1 cycle later. Required: all outputs 0 immediately; no disp_valid or lg_done after release; FSM is IDLE.

Source files
------------

// File: rtl/pixel_rom_pkg.sv
// rtl/pixel_rom_pkg.sv - shared types and constants for the pixel ROM arbiter
package pixel_rom_pkg;

    localparam int AW_DEF = 17;
    localparam int DW_DEF = 12;

    typedef logic [1:0] tag_t;

    localparam tag_t TAG_NONE = 2'b00;
    localparam tag_t TAG_DISP = 2'b01;
    localparam tag_t TAG_LG   = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - delay line tracking which requester owns each ROM read
module rd_tag_pipe
    import pixel_rom_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    logic [2*DEPTH-1:0] pipe_q;

    // Shift one tag per cycle; reset discards every in-flight owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[2*DEPTH-3:0], tag_in};
        end
    end

    assign tag_out = pipe_q[2*DEPTH-1 -: 2];

endmodule

// File: rtl/pixel_rom_arbiter.sv
// rtl/pixel_rom_arbiter.sv - display-priority arbiter for the block ROM read port
module pixel_rom_arbiter
    import pixel_rom_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int RD_LAT     = 2,
    parameter int STARVE_LIM = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_data,
    output logic          disp_valid,
    input  logic          lg_req,
    input  logic [AW-1:0] lg_addr,
    output logic          lg_ack,
    output logic [DW-1:0] lg_data,
    output logic          lg_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_en,
    input  logic [DW-1:0] mem_dout,
    output logic          starve
);

    localparam int CW = $clog2(STARVE_LIM + 1);

    state_t          state_q, state_d;
    logic            lg_win;
    tag_t            tag_in, tag_out;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_en_q, mem_en_d;
    logic            lg_ack_q, lg_ack_d;
    logic [DW-1:0]   disp_data_q, lg_data_q;
    logic            disp_valid_q, lg_done_q, starve_q;
    logic [CW-1:0]   starve_cnt_q, starve_cnt_d;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a logic grant opens the outstanding read, its returning tag closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (lg_win) state_d = ST_WAIT;
            ST_WAIT: if (tag_out == TAG_LG) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant decision: display always wins, logic only takes idle slots while no read is outstanding.
    always_comb begin
        lg_win     = !disp_req && (state_q == ST_IDLE) && lg_req;
        tag_in     = TAG_NONE;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        lg_ack_d   = 1'b0;
        if (disp_req) begin
            tag_in     = TAG_DISP;
            mem_en_d   = 1'b1;
            mem_addr_d = disp_addr;
        end else if (lg_win) begin
            tag_in     = TAG_LG;
            mem_en_d   = 1'b1;
            mem_addr_d = lg_addr;
            lg_ack_d   = 1'b1;
        end
    end

    // Starve count: grows while a pending logic request loses to the display, saturating.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!lg_req || lg_win) begin
            starve_cnt_d = '0;
        end else if (disp_req && (state_q == ST_IDLE)) begin
            if (starve_cnt_q != CW'(STARVE_LIM)) begin
                starve_cnt_d = starve_cnt_q + CW'(1);
            end
        end
    end

    // Request-side registers: ROM address/enable, acknowledge, starve tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_q   <= '0;
            mem_en_q     <= 1'b0;
            lg_ack_q     <= 1'b0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_en_q     <= mem_en_d;
            lg_ack_q     <= lg_ack_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= (starve_cnt_q >= CW'(STARVE_LIM));
        end
    end

    rd_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Return path: steer the ROM word to whichever requester owns the tag leaving the pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            lg_data_q    <= '0;
            lg_done_q    <= 1'b0;
        end else begin
            disp_valid_q <= (tag_out == TAG_DISP);
            lg_done_q    <= (tag_out == TAG_LG);
            if (tag_out == TAG_DISP) disp_data_q <= mem_dout;
            if (tag_out == TAG_LG)   lg_data_q   <= mem_dout;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_en     = mem_en_q;
    assign lg_ack     = lg_ack_q;
    assign starve     = starve_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign lg_data    = lg_data_q;
    assign lg_done    = lg_done_q;

endmodule

// File: tb/tb_pixel_rom_arbiter.sv
// tb/tb_pixel_rom_arbiter.sv - directed self-checking bench for pixel_rom_arbiter
module tb_pixel_rom_arbiter;
    import pixel_rom_pkg::*;

    localparam int AW = 17;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          lg_req;
    logic [AW-1:0] lg_addr;
    logic          lg_ack;
    logic [DW-1:0] lg_data;
    logic          lg_done;
    logic [AW-1:0] mem_addr;
    logic          mem_en;
    logic [DW-1:0] mem_dout;
    logic          starve;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pixel_rom_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(2), .STARVE_LIM(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .lg_req     (lg_req),
        .lg_addr    (lg_addr),
        .lg_ack     (lg_ack),
        .lg_data    (lg_data),
        .lg_done    (lg_done),
        .mem_addr   (mem_addr),
        .mem_en     (mem_en),
        .mem_dout   (mem_dout),
        .starve     (starve)
    );

    // ROM contents: word = addr[11:0] ^ 0xB9F ^ addr[16:12]; two-cycle registered read.
    logic [DW-1:0] rom_q1, rom_q2;
    always @(posedge clk) begin
        rom_q1 <= mem_en ? (mem_addr[11:0] ^ 12'hB9F ^ {7'd0, mem_addr[16:12]}) : 12'hEEE;
        rom_q2 <= rom_q1;
    end
    assign mem_dout = rom_q2;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; disp_req = 1'b0; disp_addr = '0; lg_req = 1'b0; lg_addr = '0;
        #3;
        checks++;
        if ({mem_addr, mem_en, disp_data, disp_valid, lg_data, lg_ack, lg_done, starve} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got mem_addr=%h mem_en=%b disp_valid=%b lg_ack=%b lg_done=%b starve=%b, want all 0",
                     mem_addr, mem_en, disp_valid, lg_ack, lg_done, starve);
        end
        step; step;
        rst = 1'b1;
        step;
        checks++;
        if (mem_en !== 1'b0 || disp_valid !== 1'b0 || lg_done !== 1'b0 || dut.state_q !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_release_idle: mem_en=%b disp_valid=%b lg_done=%b state=%b, want 0 0 0 IDLE",
                     mem_en, disp_valid, lg_done, dut.state_q);
        end
    endtask

    task automatic test_display_only;
        disp_req = 1'b1; disp_addr = 17'h00123;
        step;
        checks++;
        if (mem_addr !== 17'h00123 || mem_en !== 1'b1) begin
            failures++;
            $display("FAIL disp_only_mem: mem_addr=%h mem_en=%b, want 00123 1", mem_addr, mem_en);
        end
        disp_req = 1'b0; disp_addr = 17'h1FFFF;
        step; step;
        checks++;
        if (disp_valid !== 1'b0) begin
            failures++;
            $display("FAIL disp_only_early: disp_valid=%b after edge 2, want 0", disp_valid);
        end
        step;
        checks++;
        if (disp_valid !== 1'b1 || disp_data !== 12'hABC || lg_done !== 1'b0) begin
            failures++;
            $display("FAIL disp_only_data: disp_valid=%b disp_data=%h lg_done=%b, want 1 abc 0",
                     disp_valid, disp_data, lg_done);
        end
        step;
        checks++;
        if (disp_valid !== 1'b0 || disp_data !== 12'hABC) begin
            failures++;
            $display("FAIL disp_only_hold: disp_valid=%b disp_data=%h, want 0 abc", disp_valid, disp_data);
        end
    endtask

    task automatic test_logic_only;
        lg_req = 1'b1; lg_addr = 17'h1F000;
        step;
        checks++;
        if (lg_ack !== 1'b1 || mem_addr !== 17'h1F000 || mem_en !== 1'b1) begin
            failures++;
            $display("FAIL lg_only_grant: lg_ack=%b mem_addr=%h mem_en=%b, want 1 1f000 1", lg_ack, mem_addr, mem_en);
        end
        lg_addr = 17'h00456;
        for (int e = 1; e <= 2; e++) begin
            step;
            checks++;
            if (lg_ack !== 1'b0 || mem_en !== 1'b0 || lg_done !== 1'b0) begin
                failures++;
                $display("FAIL lg_only_wait e%0d: lg_ack=%b mem_en=%b lg_done=%b, want 0 0 0", e, lg_ack, mem_en, lg_done);
            end
        end
        step;
        checks++;
        if (lg_done !== 1'b1 || lg_data !== 12'hB80 || lg_ack !== 1'b0 || disp_valid !== 1'b0) begin
            failures++;
            $display("FAIL lg_only_done: lg_done=%b lg_data=%h lg_ack=%b disp_valid=%b, want 1 b80 0 0",
                     lg_done, lg_data, lg_ack, disp_valid);
        end
        step;
        checks++;
        if (lg_ack !== 1'b1 || mem_addr !== 17'h00456 || lg_done !== 1'b0) begin
            failures++;
            $display("FAIL lg_only_retrigger: lg_ack=%b mem_addr=%h lg_done=%b, want 1 00456 0", lg_ack, mem_addr, lg_done);
        end
        lg_req = 1'b0; lg_addr = 17'h1FFFF;
        step; step; step;
        checks++;
        if (lg_done !== 1'b1 || lg_data !== 12'hFC9) begin
            failures++;
            $display("FAIL lg_only_second: lg_done=%b lg_data=%h, want 1 fc9", lg_done, lg_data);
        end
        step;
    endtask

    task automatic test_contention;
        logic [AW-1:0] addrs [3];
        logic [DW-1:0] words [3];
        addrs[0] = 17'h00010; addrs[1] = 17'h00020; addrs[2] = 17'h00030;
        words[0] = 12'hB8F;   words[1] = 12'hBBF;   words[2] = 12'hBAF;
        lg_req = 1'b1; lg_addr = 17'h00700;
        for (int e = 0; e < 3; e++) begin
            disp_req = 1'b1; disp_addr = addrs[e];
            step;
            checks++;
            if (lg_ack !== 1'b0 || mem_addr !== addrs[e] || dut.starve_cnt_q !== 7'(e + 1)) begin
                failures++;
                $display("FAIL contention_disp e%0d: lg_ack=%b mem_addr=%h cnt=%0d, want 0 %h %0d",
                         e, lg_ack, mem_addr, dut.starve_cnt_q, addrs[e], e + 1);
            end
        end
        disp_req = 1'b0;
        step;
        checks++;
        if (lg_ack !== 1'b1 || mem_addr !== 17'h00700 || dut.starve_cnt_q !== 7'd0 || disp_valid !== 1'b1 || disp_data !== words[0]) begin
            failures++;
            $display("FAIL contention_lg: lg_ack=%b mem_addr=%h cnt=%0d disp_valid=%b disp_data=%h, want 1 00700 0 1 %h",
                     lg_ack, mem_addr, dut.starve_cnt_q, disp_valid, disp_data, words[0]);
        end
        lg_req = 1'b0;
        for (int e = 4; e <= 5; e++) begin
            step;
            checks++;
            if (disp_valid !== 1'b1 || disp_data !== words[e - 3] || lg_done !== 1'b0) begin
                failures++;
                $display("FAIL contention_ret e%0d: disp_valid=%b disp_data=%h lg_done=%b, want 1 %h 0",
                         e, disp_valid, disp_data, lg_done, words[e - 3]);
            end
        end
        step;
        checks++;
        if (lg_done !== 1'b1 || lg_data !== 12'hC9F || disp_valid !== 1'b0) begin
            failures++;
            $display("FAIL contention_lg_done: lg_done=%b lg_data=%h disp_valid=%b, want 1 c9f 0", lg_done, lg_data, disp_valid);
        end
        step;
    endtask

    task automatic test_interleave;
        logic [DW-1:0] exp_disp [11];
        logic [10:0]   exp_valid, exp_done, exp_en;
        exp_valid = 11'b010_1010_1000;
        exp_done  = 11'b000_0001_0000;
        exp_en    = 11'b000_0101_0111;
        for (int e = 0; e < 11; e++) exp_disp[e] = 12'h000;
        exp_disp[3] = 12'hB9E; exp_disp[5] = 12'hB9C; exp_disp[7] = 12'hB9A; exp_disp[9] = 12'hB98;
        lg_req = 1'b1; lg_addr = 17'h00200;
        for (int e = 0; e < 11; e++) begin
            disp_req  = (e < 8) && (e % 2 == 0);
            disp_addr = 17'h01000 | 17'(e);
            step;
            checks++;
            if (lg_ack !== (e == 1) || mem_en !== exp_en[e] || disp_valid !== exp_valid[e] || lg_done !== exp_done[e]
                || (exp_valid[e] && disp_data !== exp_disp[e]) || (exp_done[e] && lg_data !== 12'h99F)) begin
                failures++;
                $display("FAIL interleave e%0d: ack=%b en=%b dv=%b dd=%h ld=%b lgd=%h, want %b %b %b %h %b 99f",
                         e, lg_ack, mem_en, disp_valid, disp_data, lg_done, lg_data,
                         (e == 1), exp_en[e], exp_valid[e], exp_disp[e], exp_done[e]);
            end
            if (e == 1) lg_req = 1'b0;
        end
    endtask

    task automatic test_starve;
        disp_req = 1'b1; disp_addr = 17'h00000; lg_req = 1'b1; lg_addr = 17'h00333;
        for (int e = 0; e < 70; e++) begin
            step;
            if (e == 62 || e == 63) begin
                checks++;
                if (starve !== 1'b0) begin
                    failures++;
                    $display("FAIL starve_early e%0d: starve=%b, want 0", e, starve);
                end
            end
            if (e == 64 || e == 69) begin
                checks++;
                if (starve !== 1'b1 || dut.starve_cnt_q !== 7'd64 || lg_ack !== 1'b0) begin
                    failures++;
                    $display("FAIL starve_set e%0d: starve=%b cnt=%0d lg_ack=%b, want 1 64 0", e, starve, dut.starve_cnt_q, lg_ack);
                end
            end
        end
        disp_req = 1'b0;
        step;
        checks++;
        if (lg_ack !== 1'b1 || starve !== 1'b1 || dut.starve_cnt_q !== 7'd0) begin
            failures++;
            $display("FAIL starve_grant: lg_ack=%b starve=%b cnt=%0d, want 1 1 0", lg_ack, starve, dut.starve_cnt_q);
        end
        lg_req = 1'b0;
        step;
        checks++;
        if (starve !== 1'b0) begin
            failures++;
            $display("FAIL starve_clear: starve=%b, want 0", starve);
        end
        step; step;
        checks++;
        if (lg_done !== 1'b1 || lg_data !== 12'h8AC || disp_valid !== 1'b0) begin
            failures++;
            $display("FAIL starve_lg_done: lg_done=%b lg_data=%h disp_valid=%b, want 1 8ac 0", lg_done, lg_data, disp_valid);
        end
        step;
    endtask

    task automatic test_reset_midflight;
        disp_req = 1'b1; disp_addr = 17'h00777; lg_req = 1'b1; lg_addr = 17'h00888;
        step;
        disp_req = 1'b0;
        step;
        checks++;
        if (lg_ack !== 1'b1 || mem_addr !== 17'h00888) begin
            failures++;
            $display("FAIL midflight_grant: lg_ack=%b mem_addr=%h, want 1 00888", lg_ack, mem_addr);
        end
        lg_req = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_addr, mem_en, disp_data, disp_valid, lg_data, lg_ack, lg_done, starve} !== '0 || dut.state_q !== ST_IDLE) begin
            failures++;
            $display("FAIL midflight_reset: mem_addr=%h mem_en=%b disp_data=%h lg_data=%h lg_ack=%b state=%b, want all 0 IDLE",
                     mem_addr, mem_en, disp_data, lg_data, lg_ack, dut.state_q);
        end
        step; step;
        rst = 1'b1;
        for (int e = 0; e < 6; e++) begin
            step;
            checks++;
            if (disp_valid !== 1'b0 || lg_done !== 1'b0 || dut.state_q !== ST_IDLE) begin
                failures++;
                $display("FAIL midflight_after e%0d: disp_valid=%b lg_done=%b state=%b, want 0 0 IDLE",
                         e, disp_valid, lg_done, dut.state_q);
            end
        end
    endtask

    initial begin
        test_reset;
        test_display_only;
        test_logic_only;
        test_contention;
        test_interleave;
        test_starve;
        test_reset_midflight;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
